// File: rtl/adc_avg_decimator.sv
// ---------------------------------------------------------------------------
// adc_avg_decimator
//   Boxcar average + decimate of one raw ADC AXIS stream by 2^k. Each
//   completed window produces one averaged sample as a 1-cycle m_axis_tvalid
//   pulse, 1 clk after the window's last sample. There is no backpressure.
//
// Build option:
//   ADC_AVG_ROUND_EN  defined -> round half up: (sum + 2^(k-1)) >>> k
//                     undefined -> truncate toward -inf: sum >>> k
//
// Ports:
//   i_clk          clock (s_axis and m_axis share it)
//   i_rst          synchronous reset, active-high
//   i_en           1 = run, 0 = idle (partial window discarded)
//   i_clr          synchronous window restart
//   i_log2_avg     window exponent k, latched at each window start, clamped
//   s_axis_tdata   raw signed ADC sample
//   s_axis_tvalid  sample strobe
//   m_axis_tdata   averaged sample, held between pulses
//   m_axis_tvalid  1-cycle strobe per completed window
//   o_win_cnt      samples accumulated in the current window
// ---------------------------------------------------------------------------
module adc_avg_decimator #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned LOG2_AVG_MAX = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic [2:0]              i_log2_avg,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic [LOG2_AVG_MAX-1:0] o_win_cnt
);

  // Accumulator holds 2^LOG2_AVG_MAX full-scale samples without wrapping.
  localparam int unsigned ACC_WIDTH = DATA_WIDTH + LOG2_AVG_MAX;
  localparam int unsigned K_WIDTH   = $clog2(LOG2_AVG_MAX + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic signed [ACC_WIDTH-1:0]   w_acc_nxt;
  logic [LOG2_AVG_MAX-1:0]       r_cnt;
  logic [LOG2_AVG_MAX-1:0]       w_cnt_nxt;
  logic [K_WIDTH-1:0]            r_k_lat;
  logic [DATA_WIDTH-1:0]         r_tdata;
  logic                          r_tvalid;

  logic [K_WIDTH-1:0]            w_k_in;
  logic [K_WIDTH-1:0]            w_k;
  logic                          w_k_load;
  logic [LOG2_AVG_MAX-1:0]       w_cnt_max;
  logic signed [ACC_WIDTH-1:0]   w_sample_ext;
  logic signed [ACC_WIDTH-1:0]   w_sum;
  logic signed [ACC_WIDTH-1:0]   w_rnd;
  logic [DATA_WIDTH-1:0]         w_avg;
  logic                          w_fire;

  // Clamp the requested exponent to the supported range.
  always_comb begin
    if (i_log2_avg > 3'(LOG2_AVG_MAX)) begin
      w_k_in = K_WIDTH'(LOG2_AVG_MAX);
    end else begin
      w_k_in = K_WIDTH'(i_log2_avg);
    end
  end

  // The first sample of a window uses the live exponent; later ones the latched copy.
  assign w_k          = (r_cnt == '0) ? w_k_in : r_k_lat;
  assign w_cnt_max    = LOG2_AVG_MAX'((ACC_WIDTH'(1) << w_k) - ACC_WIDTH'(1));
  assign w_sample_ext = ACC_WIDTH'($signed(s_axis_tdata));
  assign w_sum        = r_acc + w_sample_ext;

`ifdef ADC_AVG_ROUND_EN
  logic signed [ACC_WIDTH-1:0] w_bias;
  assign w_bias = (w_k == '0) ? '0 : (ACC_WIDTH'(1) << (w_k - K_WIDTH'(1)));
  assign w_rnd  = w_sum + w_bias;
`else
  assign w_rnd  = w_sum;
`endif

  assign w_avg = DATA_WIDTH'(w_rnd >>> w_k);

  // Next-state and window bookkeeping. Priority: i_en=0 > i_clr > sample.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    w_k_load    = 1'b0;

    case (r_state)
      ST_IDLE:  if (i_en)  w_state_nxt = ST_ACCUM;
      ST_ACCUM: if (!i_en) w_state_nxt = ST_IDLE;
      default:             w_state_nxt = ST_IDLE;
    endcase

    if (!i_en || i_clr) begin
      w_acc_nxt = '0;
      w_cnt_nxt = '0;
    end else if (s_axis_tvalid) begin
      w_k_load = (r_cnt == '0);
      if (r_cnt == w_cnt_max) begin
        // Window complete: emit and restart so the next sample opens a new window.
        w_fire    = 1'b1;
        w_acc_nxt = '0;
        w_cnt_nxt = '0;
      end else begin
        w_acc_nxt = w_sum;
        w_cnt_nxt = r_cnt + LOG2_AVG_MAX'(1);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_k_lat  <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tvalid <= w_fire;
      if (w_k_load) r_k_lat <= w_k;
      if (w_fire)   r_tdata <= w_avg;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign o_win_cnt     = r_cnt;

endmodule

// File: tb/tb_adc_avg_decimator.sv
// ---------------------------------------------------------------------------
// tb_adc_avg_decimator
//   Self-checking bench for adc_avg_decimator. A window-level reference model
//   (queue of samples per window, floor division on longint) predicts the
//   output each cycle; key scenarios are also checked against fixed values.
// ---------------------------------------------------------------------------
module tb_adc_avg_decimator;

  localparam int unsigned DW = 32;
  localparam int unsigned LM = 4;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_en;
  logic          i_clr;
  logic [2:0]    i_log2_avg;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic [LM-1:0] o_win_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  longint        win_q[$];
  int            win_k;
  bit            exp_vld;
  logic [DW-1:0] exp_data;

  always #5 clk = ~clk;

  adc_avg_decimator #(.DATA_WIDTH(DW), .LOG2_AVG_MAX(LM)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_clr         (i_clr),
    .i_log2_avg    (i_log2_avg),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .o_win_cnt     (o_win_cnt)
  );

  // Mean of a window of 2^k samples, floor (or round half up) of sum / 2^k.
  function automatic logic [DW-1:0] ref_avg(input longint s, input int k);
    longint d, t, q;
    d = longint'(1) << k;
    t = s;
`ifdef ADC_AVG_ROUND_EN
    if (k > 0) t = s + d / 2;
`endif
    q = t / d;
    if ((t % d != 0) && (t < 0)) q = q - 1;
    return DW'(q);
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void model_edge();
    longint sum;
    exp_vld = 1'b0;
    if (i_rst) begin
      win_q.delete();
      win_k    = 0;
      exp_data = '0;
    end else if (!i_en || i_clr) begin
      win_q.delete();
    end else if (s_axis_tvalid) begin
      if (win_q.size() == 0) win_k = (int'(i_log2_avg) > LM) ? LM : int'(i_log2_avg);
      win_q.push_back(longint'($signed(s_axis_tdata)));
      if (win_q.size() == (1 << win_k)) begin
        sum = 0;
        foreach (win_q[j]) sum += win_q[j];
        exp_data = ref_avg(sum, win_k);
        exp_vld  = 1'b1;
        win_q.delete();
      end
    end
  endfunction

  // Drive one cycle of inputs, clock it, update the model, sample #1 later.
  task automatic cyc(input bit en, input bit clr, input bit vld, input logic [DW-1:0] d);
    i_en = en; i_clr = clr; s_axis_tvalid = vld; s_axis_tdata = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_log2_avg = 3'd0;
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b1, 32'h1234_5678);
    if ({m_axis_tvalid, m_axis_tdata, o_win_cnt} !== {1'b0, 32'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset: got vld=%b data=%h cnt=%0d, want vld=0 data=0 cnt=0",
               m_axis_tvalid, m_axis_tdata, o_win_cnt);
    end
    checks++;
    i_rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_basic();
    int s [4] = '{10, 11, 12, 13};
    i_log2_avg = 3'd2;
    cyc(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b1, DW'(s[i]));
      if ({m_axis_tvalid, m_axis_tdata, o_win_cnt} !== {exp_vld, exp_data, LM'(win_q.size())}) begin
        errors++;
        $display("FAIL basic[%0d]: got vld=%b data=%h cnt=%0d, want vld=%b data=%h cnt=%0d", i,
                 m_axis_tvalid, m_axis_tdata, o_win_cnt, exp_vld, exp_data, win_q.size());
      end
      checks++;
    end
`ifdef ADC_AVG_ROUND_EN
    if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 32'd12}) begin
`else
    if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 32'd11}) begin
`endif
      errors++;
      $display("FAIL basic_const: got vld=%b data=%0d, want vld=1 data=11/12 (trunc/round)",
               m_axis_tvalid, m_axis_tdata);
    end
    checks++;
    cyc(1'b1, 1'b0, 1'b0, '0);
    if (m_axis_tvalid !== 1'b0 || o_win_cnt !== 4'd0) begin
      errors++;
      $display("FAIL basic_pulse_width: got vld=%b cnt=%0d, want vld=0 cnt=0", m_axis_tvalid, o_win_cnt);
    end
    checks++;
  endtask

  task automatic test_negative();
    int s [4] = '{-5, -6, -6, -6};
    i_log2_avg = 3'd2;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b1, DW'(s[i]));
      if ({m_axis_tvalid, m_axis_tdata, o_win_cnt} !== {exp_vld, exp_data, LM'(win_q.size())}) begin
        errors++;
        $display("FAIL negative[%0d]: got vld=%b data=%h cnt=%0d, want vld=%b data=%h cnt=%0d", i,
                 m_axis_tvalid, m_axis_tdata, o_win_cnt, exp_vld, exp_data, win_q.size());
      end
      checks++;
    end
    if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 32'hFFFF_FFFA}) begin
      errors++;
      $display("FAIL negative_const: got vld=%b data=%h, want vld=1 data=fffffffa", m_axis_tvalid, m_axis_tdata);
    end
    checks++;
  endtask

  task automatic test_passthrough();
    logic [DW-1:0] s [2] = '{32'h7FFF_FFFF, 32'h8000_0000};
    i_log2_avg = 3'd0;
    cyc(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b1, s[i]);
      if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, s[i]} || o_win_cnt !== 4'd0) begin
        errors++;
        $display("FAIL passthrough[%0d]: got vld=%b data=%h cnt=%0d, want vld=1 data=%h cnt=0", i,
                 m_axis_tvalid, m_axis_tdata, o_win_cnt, s[i]);
      end
      checks++;
    end
  endtask

  task automatic test_fullscale();
    logic [DW-1:0] v [2] = '{32'h7FFF_FFFF, 32'h8000_0000};
    i_log2_avg = 3'd4;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) begin
        cyc(1'b1, 1'b0, 1'b1, v[r]);
        if ({m_axis_tvalid, m_axis_tdata, o_win_cnt} !== {exp_vld, exp_data, LM'(win_q.size())}) begin
          errors++;
          $display("FAIL fullscale[%0d][%0d]: got vld=%b data=%h cnt=%0d, want vld=%b data=%h cnt=%0d", r, i,
                   m_axis_tvalid, m_axis_tdata, o_win_cnt, exp_vld, exp_data, win_q.size());
        end
        checks++;
      end
      if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, v[r]}) begin
        errors++;
        $display("FAIL fullscale_const[%0d]: got vld=%b data=%h, want vld=1 data=%h", r,
                 m_axis_tvalid, m_axis_tdata, v[r]);
      end
      checks++;
    end
  endtask

  task automatic test_clr_kchange();
    int pulses = 0;
    int    d  [8] = '{1, 2, 99, 4, 8, 12, 16, 0};
    bit    cl [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    bit    vl [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    i_log2_avg = 3'd2;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) i_log2_avg = 3'd1;
      cyc(1'b1, cl[i], vl[i], DW'(d[i]));
      if (m_axis_tvalid === 1'b1) pulses++;
      if ({m_axis_tvalid, m_axis_tdata, o_win_cnt} !== {exp_vld, exp_data, LM'(win_q.size())}) begin
        errors++;
        $display("FAIL clr[%0d]: got vld=%b data=%h cnt=%0d, want vld=%b data=%h cnt=%0d", i,
                 m_axis_tvalid, m_axis_tdata, o_win_cnt, exp_vld, exp_data, win_q.size());
      end
      checks++;
    end
    if (pulses !== 1 || m_axis_tdata !== 32'd10) begin
      errors++;
      $display("FAIL clr_const: got pulses=%0d data=%0d, want pulses=1 data=10", pulses, m_axis_tdata);
    end
    checks++;
    // Window opened after the exponent change is 2 samples long.
    cyc(1'b1, 1'b0, 1'b1, 32'd3);
    cyc(1'b1, 1'b0, 1'b1, 32'd5);
    if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 32'd4}) begin
      errors++;
      $display("FAIL kchange: got vld=%b data=%0d, want vld=1 data=4", m_axis_tvalid, m_axis_tdata);
    end
    checks++;
  endtask

  task automatic test_abort();
    i_log2_avg = 3'd2;
    // Partial window dropped by i_en=0, then a gapped window completes.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 32'd100);
    cyc(1'b0, 1'b0, 1'b1, 32'd100);
    if (m_axis_tvalid !== 1'b0 || o_win_cnt !== 4'd0) begin
      errors++;
      $display("FAIL abort_en: got vld=%b cnt=%0d, want vld=0 cnt=0", m_axis_tvalid, o_win_cnt);
    end
    checks++;
    cyc(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, i[0], DW'(i * 7 - 20));
      if ({m_axis_tvalid, m_axis_tdata, o_win_cnt} !== {exp_vld, exp_data, LM'(win_q.size())}) begin
        errors++;
        $display("FAIL gaps[%0d]: got vld=%b data=%h cnt=%0d, want vld=%b data=%h cnt=%0d", i,
                 m_axis_tvalid, m_axis_tdata, o_win_cnt, exp_vld, exp_data, win_q.size());
      end
      checks++;
    end
    // Reset mid-window: no pulse, output data cleared.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 32'd50);
    i_rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 32'd50);
    i_rst = 1'b0;
    if ({m_axis_tvalid, m_axis_tdata, o_win_cnt} !== {1'b0, 32'h0, 4'h0}) begin
      errors++;
      $display("FAIL abort_rst: got vld=%b data=%h cnt=%0d, want vld=0 data=0 cnt=0",
               m_axis_tvalid, m_axis_tdata, o_win_cnt);
    end
    checks++;
    cyc(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 32'd8);
    if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 32'd8}) begin
      errors++;
      $display("FAIL abort_resume: got vld=%b data=%0d, want vld=1 data=8", m_axis_tvalid, m_axis_tdata);
    end
    checks++;
  endtask

  task automatic test_random();
    bit en_prev = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      bit en, clr, vld;
      logic [DW-1:0] d;
      en  = ($urandom_range(0, 19) != 0);
      clr = ($urandom_range(0, 39) == 0);
      vld = ($urandom_range(0, 9) < 6) && !(en && !en_prev);
      case ($urandom_range(0, 5))
        0:       d = 32'h7FFF_FFFF;
        1:       d = 32'h8000_0000;
        2:       d = DW'($urandom_range(0, 40)) - 32'd20;
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) i_log2_avg = 3'($urandom_range(0, 7));
      en_prev = en;
      cyc(en, clr, vld, d);
      if ({m_axis_tvalid, m_axis_tdata, o_win_cnt} !== {exp_vld, exp_data, LM'(win_q.size())}) begin
        errors++;
        $display("FAIL random[%0d]: got vld=%b data=%h cnt=%0d, want vld=%b data=%h cnt=%0d", i,
                 m_axis_tvalid, m_axis_tdata, o_win_cnt, exp_vld, exp_data, win_q.size());
      end
      checks++;
    end
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_clr = 1'b0; i_log2_avg = 3'd0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    win_k = 0; exp_vld = 1'b0; exp_data = '0;
    test_reset();
    test_basic();
    test_negative();
    test_passthrough();
    test_fullscale();
    test_clr_kchange();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
